usb_tx_serializer: RTL and testbench



---
 rtl/usb_tx_pkg.sv | 49 ++++
 rtl/usb_tx_bit_encoder.sv | 80 ++++++++
 rtl/usb_tx_serializer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB packet transmitter.
//
// Contents:
//   tx_state_e      - transmitter state encoding.
//   SYNC_BYTE       - SYNC pattern, sent LSB first (KJKJKJKK on the line).
//   CRC16_*         - CRC-16/USB constants (reflected polynomial, init value).
//   line_j/k/se0    - {D+, D-} encodings for J, K and SE0 given the speed mode.
//   crc16_step      - one-bit update of the reflected CRC-16.
//
// Optional feature macro: USB_TX_CRC16_EN adds the CRC_LO/CRC_HI states.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
`ifdef USB_TX_CRC16_EN
        ST_CRC_LO,
        ST_CRC_HI,
`endif
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    localparam logic [7:0]  SYNC_BYTE       = 8'h80;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    // Full speed idles with D+ high; low speed swaps the pair.
    function automatic logic [1:0] line_j(input logic full_speed);
        return full_speed ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] line_k(input logic full_speed);
        return full_speed ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] line_se0();
        return 2'b00;
    endfunction

    // LSB-first CRC: feedback is the outgoing LSB xor the new data bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[0] ^ b;
        return {1'b0, crc[15:1]} ^ (fb ? CRC16_POLY_REFL : 16'h0000);
    endfunction

endpackage

// File: rtl/usb_tx_bit_encoder.sv
// Line encoder: bit stuffing, NRZI and the registered D+/D- drive.
//
// Ports:
//   clk, n_rst            - clock, asynchronous active-low reset.
//   strobe                - a new bit period starts; the line updates on this edge.
//   bit_in                - logical bit to send when neither se0_req nor j_req.
//   se0_req               - drive SE0 for this bit period.
//   j_req                 - drive J for this bit period (end of EOP).
//   stall                 - a stuffed 0 is being sent instead of the request;
//                           the caller must present the same request again.
//   tx_d_plus, tx_d_minus - registered line outputs.
module usb_tx_bit_encoder
    import usb_tx_pkg::*;
#(
    parameter int FULL_SPEED  = 1,
    parameter int STUFF_LIMIT = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic strobe,
    input  logic bit_in,
    input  logic se0_req,
    input  logic j_req,
    output logic stall,
    output logic tx_d_plus,
    output logic tx_d_minus
);

    localparam int   ONES_W = $clog2(STUFF_LIMIT + 1);
    localparam logic FS     = (FULL_SPEED != 0);

    logic              level_q, level_d;   // NRZI level, 1 = J
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [1:0]        line_q, line_d;

    // A pending stuff pre-empts whatever the caller asks for, including SE0,
    // so a stuff owed after the final payload bit still precedes EOP.
    assign stall = strobe && (ones_q == ONES_W'(STUFF_LIMIT));

    always_comb begin
        level_d = level_q;
        ones_d  = ones_q;
        line_d  = line_q;
        if (strobe) begin
            if (stall) begin
                level_d = ~level_q;
                ones_d  = '0;
            end else if (se0_req || j_req) begin
                // The packet after this EOP starts from J.
                level_d = 1'b1;
                ones_d  = '0;
            end else if (bit_in) begin
                ones_d  = ones_q + ONES_W'(1);
            end else begin
                level_d = ~level_q;
                ones_d  = '0;
            end
            if (se0_req && !stall)
                line_d = line_se0();
            else
                line_d = level_d ? line_j(FS) : line_k(FS);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            level_q <= 1'b1;
            ones_q  <= '0;
            line_q  <= line_j(FS);
        end else begin
            level_q <= level_d;
            ones_q  <= ones_d;
            line_q  <= line_d;
        end
    end

    assign tx_d_plus  = line_q[1];
    assign tx_d_minus = line_q[0];

endmodule

// File: rtl/usb_tx_serializer.sv
// USB packet transmitter: byte handshake in, differential USB line out.
// Prepends SYNC, shifts bytes out LSB first, hands bits to the stuffing/NRZI
// encoder and finishes with EOP (2 bit times SE0, 1 bit time J).
//
// Ports:
//   clk, n_rst             - USB clock, asynchronous active-low reset.
//   tx_data/valid/last     - byte input; tx_last marks the final payload byte.
//   tx_ready               - one-byte holding register is empty.
//   tx_d_plus, tx_d_minus  - USB line.
//   is_txing               - pad output enable.
//   tx_underrun            - one-cycle pulse when the packet is truncated.
//   tx_done                - one-cycle pulse when the EOP J bit completes.
//
// Optional feature macro: USB_TX_CRC16_EN appends CRC-16/USB after the last byte.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int FULL_SPEED   = 1,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_d_plus,
    output logic       tx_d_minus,
    output logic       is_txing,
    output logic       tx_underrun,
    output logic       tx_done
);

    localparam int               CNT_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Index of the next bit to send; 8 means the current byte is exhausted.
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             last_q, last_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_last_q, hold_last_d;
    logic             hold_full_q, hold_full_d;
    logic             eop_q, eop_d;
    logic             is_txing_q, is_txing_d;
    logic             underrun_q, underrun_d;
    logic             done_q, done_d;
`ifdef USB_TX_CRC16_EN
    logic [15:0]      crc_q, crc_d;
`endif

    logic       accept, avail, bit_end, take_hold, take_direct;
    logic [7:0] nxt_byte;
    logic       nxt_last;
    logic       enc_strobe, enc_bit, enc_se0, enc_j, enc_stall;

    assign tx_ready = !hold_full_q;
    assign accept   = tx_valid && !hold_full_q;
    // A byte is available from hold or, when hold is empty, straight from the input.
    assign avail    = hold_full_q || tx_valid;
    assign nxt_byte = hold_full_q ? hold_q : tx_data;
    assign nxt_last = hold_full_q ? hold_last_q : tx_last;
    assign bit_end  = (state_q != ST_IDLE) && (cnt_q == CNT_MAX);
    // EOP_J ends without a new line symbol; the line simply stays J.
    assign enc_strobe = (state_q == ST_IDLE) ? avail : (bit_end && state_q != ST_EOP_J);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        last_d      = last_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        eop_d       = eop_q;
        is_txing_d  = is_txing_q;
        underrun_d  = 1'b0;
        done_d      = 1'b0;
        take_hold   = 1'b0;
        take_direct = 1'b0;
        enc_bit     = 1'b0;
        enc_se0     = 1'b0;
        enc_j       = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_d       = crc_q;
`endif
        cnt_d = (state_q == ST_IDLE || bit_end) ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (avail) begin
                    state_d    = ST_SYNC;
                    enc_bit    = SYNC_BYTE[0];
                    idx_d      = 4'd1;
                    last_d     = 1'b0;
                    is_txing_d = 1'b1;
`ifdef USB_TX_CRC16_EN
                    crc_d      = CRC16_INIT;
`endif
                end
            end

            ST_SYNC, ST_DATA: begin
                if (bit_end && !enc_stall) begin
                    if (!idx_q[3]) begin
                        if (state_q == ST_SYNC) begin
                            enc_bit = SYNC_BYTE[idx_q[2:0]];
                        end else begin
                            enc_bit = shift_q[idx_q[2:0]];
`ifdef USB_TX_CRC16_EN
                            crc_d   = crc16_step(crc_q, shift_q[idx_q[2:0]]);
`endif
                        end
                        idx_d = idx_q + 4'd1;
                    end else if (last_q) begin
`ifdef USB_TX_CRC16_EN
                        state_d = ST_CRC_LO;
                        enc_bit = ~crc_q[0];
                        idx_d   = 4'd1;
`else
                        state_d = ST_EOP_SE0;
                        enc_se0 = 1'b1;
                        eop_d   = 1'b0;
`endif
                    end else if (avail) begin
                        take_hold   = hold_full_q;
                        take_direct = !hold_full_q;
                        state_d     = ST_DATA;
                        shift_d     = nxt_byte;
                        last_d      = nxt_last;
                        enc_bit     = nxt_byte[0];
                        idx_d       = 4'd1;
`ifdef USB_TX_CRC16_EN
                        crc_d       = crc16_step(crc_q, nxt_byte[0]);
`endif
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = ST_EOP_SE0;
                        enc_se0    = 1'b1;
                        eop_d      = 1'b0;
                    end
                end
            end

`ifdef USB_TX_CRC16_EN
            // The complemented CRC goes out low byte first, LSB first.
            ST_CRC_LO: begin
                if (bit_end && !enc_stall) begin
                    if (!idx_q[3]) begin
                        enc_bit = ~crc_q[{1'b0, idx_q[2:0]}];
                        idx_d   = idx_q + 4'd1;
                    end else begin
                        state_d = ST_CRC_HI;
                        enc_bit = ~crc_q[8];
                        idx_d   = 4'd1;
                    end
                end
            end

            ST_CRC_HI: begin
                if (bit_end && !enc_stall) begin
                    if (!idx_q[3]) begin
                        enc_bit = ~crc_q[{1'b1, idx_q[2:0]}];
                        idx_d   = idx_q + 4'd1;
                    end else begin
                        state_d = ST_EOP_SE0;
                        enc_se0 = 1'b1;
                        eop_d   = 1'b0;
                    end
                end
            end
`endif

            ST_EOP_SE0: begin
                if (bit_end && !enc_stall) begin
                    if (!eop_q) begin
                        enc_se0 = 1'b1;
                        eop_d   = 1'b1;
                    end else begin
                        enc_j   = 1'b1;
                        state_d = ST_EOP_J;
                    end
                end
            end

            ST_EOP_J: begin
                if (bit_end) begin
                    state_d    = ST_IDLE;
                    is_txing_d = 1'b0;
                    done_d     = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (take_hold)
            hold_full_d = 1'b0;
        if (accept && !take_direct) begin
            hold_full_d = 1'b1;
            hold_d      = tx_data;
            hold_last_d = tx_last;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            last_q      <= 1'b0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            eop_q       <= 1'b0;
            is_txing_q  <= 1'b0;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_q       <= CRC16_INIT;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            eop_q       <= eop_d;
            is_txing_q  <= is_txing_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
`ifdef USB_TX_CRC16_EN
            crc_q       <= crc_d;
`endif
        end
    end

    usb_tx_bit_encoder #(
        .FULL_SPEED (FULL_SPEED),
        .STUFF_LIMIT(STUFF_LIMIT)
    ) u_enc (
        .clk       (clk),
        .n_rst     (n_rst),
        .strobe    (enc_strobe),
        .bit_in    (enc_bit),
        .se0_req   (enc_se0),
        .j_req     (enc_j),
        .stall     (enc_stall),
        .tx_d_plus (tx_d_plus),
        .tx_d_minus(tx_d_minus)
    );

    assign is_txing    = is_txing_q;
    assign tx_underrun = underrun_q;
    assign tx_done     = done_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: a full-speed and a low-speed instance share
// the stimulus; captured line traces are compared against a packet model
// built from the protocol rules (SYNC, stuffing, NRZI, EOP).
module tb_usb_tx_serializer;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;

    logic fs_ready, fs_dp, fs_dm, fs_txing, fs_und, fs_done;
    logic ls_ready, ls_dp, ls_dm, ls_txing, ls_und, ls_done;

    always #5 clk = ~clk;

    usb_tx_serializer #(.CLKS_PER_BIT(CPB), .FULL_SPEED(1), .STUFF_LIMIT(6)) dut_fs (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(fs_ready), .tx_d_plus(fs_dp), .tx_d_minus(fs_dm), .is_txing(fs_txing),
        .tx_underrun(fs_und), .tx_done(fs_done));

    usb_tx_serializer #(.CLKS_PER_BIT(CPB), .FULL_SPEED(0), .STUFF_LIMIT(6)) dut_ls (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(ls_ready), .tx_d_plus(ls_dp), .tx_d_minus(ls_dm), .is_txing(ls_txing),
        .tx_underrun(ls_und), .tx_done(ls_done));

    localparam logic [1:0] SYM_J = 2'b10, SYM_K = 2'b01, SYM_SE0 = 2'b00;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] pkt[$];
    logic [1:0] exp_sym[$];
    logic [1:0] cap_fs[$], cap_ls[$], cap_first[$];
    int und_idx, und_cnt, done_idx, done_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ls_of(input logic [1:0] s);
        return (s == SYM_SE0) ? SYM_SE0 : {s[0], s[1]};
    endfunction

    // Model: logical bit list -> stuffed bits -> NRZI symbols -> EOP.
    task automatic build_expected(input bit with_last);
        bit raw[$];
        bit st[$];
        int ones;
        logic lvl;
`ifdef USB_TX_CRC16_EN
        logic [15:0] crc;
        logic fb;
        crc = 16'hFFFF;
`endif
        exp_sym.delete();
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        foreach (pkt[b]) begin
            for (int i = 0; i < 8; i++) begin
                raw.push_back(pkt[b][i]);
`ifdef USB_TX_CRC16_EN
                fb  = crc[0] ^ pkt[b][i];
                crc = crc >> 1;
                if (fb) crc = crc ^ 16'hA001;
`endif
            end
        end
`ifdef USB_TX_CRC16_EN
        if (with_last) begin
            crc = ~crc;
            for (int i = 0; i < 16; i++) raw.push_back(crc[i]);
        end
`else
        if (with_last) ones = 0;
`endif
        ones = 0;
        foreach (raw[k]) begin
            st.push_back(raw[k]);
            ones = raw[k] ? ones + 1 : 0;
            if (ones == 6) begin
                st.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = 1'b1;
        foreach (st[k]) begin
            if (!st[k]) lvl = ~lvl;
            exp_sym.push_back(lvl ? SYM_J : SYM_K);
        end
        exp_sym.push_back(SYM_SE0);
        exp_sym.push_back(SYM_SE0);
        exp_sym.push_back(SYM_J);
    endtask

    task automatic run_packet(input bit with_last);
        cap_fs.delete();
        cap_ls.delete();
        und_idx = -1; und_cnt = 0; done_idx = -1; done_cnt = 0;
        @(negedge clk);
        fork
            begin : feeder
                int fg;
                for (int i = 0; i < pkt.size(); i++) begin
                    tx_data  = pkt[i];
                    tx_last  = with_last && (i == pkt.size() - 1);
                    tx_valid = 1'b1;
                    fg = 0;
                    while (!fs_ready && fg < 4000) begin
                        @(negedge clk);
                        fg++;
                    end
                    check($sformatf("feed_ready_b%0d", i), fs_ready, 1);
                    @(negedge clk);
                end
                tx_valid = 1'b0;
                tx_last  = 1'b0;
            end
            begin : monitor
                int g, n;
                g = 0; n = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!fs_txing && g < 4000);
                check("txing_rise", fs_txing, 1);
                while (fs_txing && n < 8000) begin
                    cap_fs.push_back({fs_dp, fs_dm});
                    cap_ls.push_back({ls_dp, ls_dm});
                    if (fs_und) begin und_cnt++; und_idx = n; end
                    if (fs_done) done_cnt++;
                    n++;
                    @(negedge clk);
                end
                if (fs_done) begin done_cnt++; done_idx = n; end
                @(negedge clk);
                if (fs_done) done_cnt++;
            end
        join
    endtask

    task automatic compare_capture(input string tag, input int exp_und_idx);
        logic [1:0] of, ol;
        check({tag, "_len"}, cap_fs.size(), exp_sym.size() * CPB);
        foreach (exp_sym[k]) begin
            of = (k * CPB < cap_fs.size()) ? cap_fs[k * CPB] : 2'bxx;
            ol = (k * CPB < cap_ls.size()) ? cap_ls[k * CPB] : 2'bxx;
            for (int c = 1; c < CPB; c++) begin
                if (k * CPB + c >= cap_fs.size()) begin
                    of = 2'bxx; ol = 2'bxx;
                end else begin
                    if (cap_fs[k * CPB + c] !== exp_sym[k]) of = cap_fs[k * CPB + c];
                    if (cap_ls[k * CPB + c] !== ls_of(exp_sym[k])) ol = cap_ls[k * CPB + c];
                end
            end
            check($sformatf("%s_fs_bit%0d", tag, k), of, exp_sym[k]);
            check($sformatf("%s_ls_bit%0d", tag, k), ol, ls_of(exp_sym[k]));
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_idx"}, done_idx, exp_sym.size() * CPB);
        check({tag, "_und_cnt"}, und_cnt, (exp_und_idx < 0) ? 0 : 1);
        if (exp_und_idx >= 0) check({tag, "_und_idx"}, und_idx, exp_und_idx);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_fs_line"}, {fs_dp, fs_dm}, SYM_J);
        check({tag, "_ls_line"}, {ls_dp, ls_dm}, ls_of(SYM_J));
        check({tag, "_txing"}, fs_txing, 0);
        check({tag, "_ready"}, fs_ready, 1);
        check({tag, "_und"}, fs_und, 0);
        check({tag, "_done"}, fs_done, 0);
    endtask

    initial begin
        logic [7:0] dec[$];
        logic [1:0] prev, s;
        logic [7:0] acc;
        int ones, nb, npk, r;
        bit skip;

        // Reset
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        n_rst = 1'b1;
        @(negedge clk);
        check_reset_state("post_reset");

        // Single 0x00 byte packet
        pkt = {8'h00};
        build_expected(1'b1);
        run_packet(1'b1);
        compare_capture("b00", -1);
        cap_first = cap_fs;

        // 0xFF 0xFF: two stuffed bits
        pkt = {8'hFF, 8'hFF};
        build_expected(1'b1);
        run_packet(1'b1);
        compare_capture("bFF", -1);

        // 0xA5 (low-speed inversion checked alongside)
        pkt = {8'hA5};
        build_expected(1'b1);
        run_packet(1'b1);
        compare_capture("bA5", -1);

        // Underrun after 0x11: truncates right after bit 7 (16 bit times in)
        pkt = {8'h11};
        build_expected(1'b0);
        run_packet(1'b0);
        compare_capture("und", 16 * CPB);

        // Reset in the middle of DATA
        repeat (4) @(negedge clk);
        tx_data = 8'h3C; tx_last = 1'b0; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h5A;
        repeat (12 * CPB) @(negedge clk);
        tx_valid = 1'b0;
        check("mid_txing_before", fs_txing, 1);
        #2 n_rst = 1'b0;
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        pkt = {8'h00};
        build_expected(1'b1);
        run_packet(1'b1);
        compare_capture("replay", -1);
        check("replay_len_vs_first", cap_fs.size(), cap_first.size());
        for (int k = 0; k < cap_first.size(); k += CPB)
            check($sformatf("replay_vs_first_%0d", k / CPB),
                  (k < cap_fs.size()) ? cap_fs[k] : 2'bxx, cap_first[k]);

        // "123456789": decode the line independently
        pkt = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        build_expected(1'b1);
        run_packet(1'b1);
        compare_capture("ascii", -1);
        prev = SYM_J; ones = 0; skip = 1'b0; nb = 0; acc = 8'h00; npk = 0;
        for (int k = 0; k * CPB + CPB / 2 < cap_fs.size(); k++) begin
            s = cap_fs[k * CPB + CPB / 2];
            if (s == SYM_SE0) break;
            if (skip) begin
                skip = 1'b0;
            end else begin
                npk++;
                if (npk > 8) begin
                    acc = {(s == prev), acc[7:1]};
                    nb++;
                    if (nb == 8) begin dec.push_back(acc); nb = 0; end
                end
                ones = (s == prev) ? ones + 1 : 0;
                if (ones == 6) begin skip = 1'b1; ones = 0; end
            end
            prev = s;
        end
`ifdef USB_TX_CRC16_EN
        check("ascii_dec_count", dec.size(), 11);
        check("ascii_crc_lo", (dec.size() > 9) ? dec[9] : 8'hxx, 8'hC8);
        check("ascii_crc_hi", (dec.size() > 10) ? dec[10] : 8'hxx, 8'hB4);
`else
        check("ascii_dec_count", dec.size(), 9);
        check("ascii_last", (dec.size() > 8) ? dec[8] : 8'hxx, 8'h39);
`endif

        // Randomized packets
        for (int p = 0; p < 6; p++) begin
            pkt.delete();
            r = $urandom_range(1, 5);
            for (int i = 0; i < r; i++)
                pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            build_expected(1'b1);
            run_packet(1'b1);
            compare_capture($sformatf("rnd%0d", p), -1);
        end

        repeat (4) @(negedge clk);
        check_reset_state("final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
